// File: rtl/pio_tx_cpl_engine.sv
// pio_tx_cpl_engine: completion transmit stage of the KC705 PIO endpoint.
// Takes one captured non-posted read, reads the memory-access block after a
// fixed latency and sends a 3DW-header completion as two 64-bit AXI-Stream beats.
// Optional feature macro: PIO_CPL_UR_EN. When it is defined, reads to the
// unmapped region (req_addr[13:12] == 2'b00) are answered with an Unsupported
// Request completion without data, and the memory read wait is skipped.
module pio_tx_cpl_engine #(
    parameter int TCQ    = 1,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic        req_compl,
    input  logic [2:0]  req_tc,
    input  logic        req_td,
    input  logic        req_ep,
    input  logic [1:0]  req_attr,
    input  logic [15:0] req_rid,
    input  logic [7:0]  req_tag,
    input  logic [3:0]  req_be,
    input  logic [13:0] req_addr,
    input  logic [15:0] completer_id,
    output logic        compl_done,
    output logic [13:0] rd_addr,
    output logic [3:0]  rd_be,
    input  logic [31:0] rd_data,
    input  logic        s_axis_tx_tready,
    output logic        s_axis_tx_tvalid,
    output logic [63:0] s_axis_tx_tdata,
    output logic [7:0]  s_axis_tx_tkeep,
    output logic        s_axis_tx_tlast,
    output logic [3:0]  s_axis_tx_tuser
);

    // An out-of-range latency or a negative clock-to-out delay stops elaboration.
    generate
        if (RD_LAT < 1 || RD_LAT > 4 || TCQ < 0) begin : g_bad_param
            pio_tx_cpl_engine_illegal_parameter u_bad ();
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RD_WAIT, HDR, DATA} state_t;

    state_t      state;
    logic [2:0]  lat_cnt;
    logic [2:0]  tc_q;
    logic        td_q;
    logic        ep_q;
    logic [1:0]  attr_q;
    logic [15:0] rid_q;
    logic [7:0]  tag_q;
    logic [31:0] data_q;
    logic        ur_flag;

`ifdef PIO_CPL_UR_EN
    logic ur_q;
    logic req_ur;
    assign req_ur  = (req_addr[13:12] == 2'b00);
    assign ur_flag = ur_q;
`else
    assign ur_flag = 1'b0;
`endif

    assign s_axis_tx_tuser = 4'h0;

    // Number of enabled bytes spanned by the first-DW byte enables.
    function automatic logic [11:0] calc_byte_count(input logic [3:0] be);
        casez (be)
            4'b1??1:                   calc_byte_count = 12'd4;
            4'b01?1, 4'b1?10:          calc_byte_count = 12'd3;
            4'b0011, 4'b0110, 4'b1100: calc_byte_count = 12'd2;
            default:                   calc_byte_count = 12'd1;
        endcase
    endfunction

    // Byte address of the first enabled byte within the DW, low 7 bits.
    function automatic logic [6:0] calc_lower_addr(input logic [4:0] a, input logic [3:0] be);
        logic [1:0] lo2;
        if (be[0])      lo2 = 2'd0;
        else if (be[1]) lo2 = 2'd1;
        else if (be[2]) lo2 = 2'd2;
        else if (be[3]) lo2 = 2'd3;
        else            lo2 = 2'd0;
        calc_lower_addr = {a, lo2};
    endfunction

    // Header DW0: CplD (fmt 10, length 1) or Cpl without data (fmt 00, length 0).
    function automatic logic [31:0] make_dw0(input logic [2:0] tc, input logic td, input logic ep,
                                             input logic [1:0] attr, input logic ur);
        make_dw0 = {1'b0, (ur ? 2'b00 : 2'b10), 5'b01010, 1'b0, tc, 4'b0000,
                    td, ep, attr, 2'b00, (ur ? 10'd0 : 10'd1)};
    endfunction

    // Header DW1: completer ID, status (UR when flagged) and byte count.
    function automatic logic [31:0] make_dw1(input logic [15:0] cid, input logic ur, input logic [3:0] be);
        make_dw1 = {cid, (ur ? 3'b001 : 3'b000), 1'b0, calc_byte_count(be)};
    endfunction

    // Header DW2: requester ID, tag and lower address.
    function automatic logic [31:0] make_dw2(input logic [15:0] rid, input logic [7:0] tag,
                                             input logic [4:0] a, input logic [3:0] be);
        make_dw2 = {rid, tag, 1'b0, calc_lower_addr(a, be)};
    endfunction

    // Request capture, read-latency wait and two-beat TLP emission with registered outputs.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state            <= IDLE;
            lat_cnt          <= '0;
            tc_q             <= '0;
            td_q             <= 1'b0;
            ep_q             <= 1'b0;
            attr_q           <= '0;
            rid_q            <= '0;
            tag_q            <= '0;
            data_q           <= '0;
            rd_addr          <= '0;
            rd_be            <= '0;
            compl_done       <= 1'b0;
            s_axis_tx_tvalid <= 1'b0;
            s_axis_tx_tdata  <= '0;
            s_axis_tx_tkeep  <= '0;
            s_axis_tx_tlast  <= 1'b0;
`ifdef PIO_CPL_UR_EN
            ur_q             <= 1'b0;
`endif
        end else begin
            compl_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_compl) begin
                        tc_q    <= req_tc;
                        td_q    <= req_td;
                        ep_q    <= req_ep;
                        attr_q  <= req_attr;
                        rid_q   <= req_rid;
                        tag_q   <= req_tag;
                        rd_addr <= req_addr;
                        rd_be   <= req_be;
                        lat_cnt <= 3'(RD_LAT);
`ifdef PIO_CPL_UR_EN
                        ur_q    <= req_ur;
                        if (req_ur) begin
                            state            <= HDR;
                            s_axis_tx_tvalid <= 1'b1;
                            s_axis_tx_tdata  <= {make_dw1(completer_id, 1'b1, req_be),
                                                 make_dw0(req_tc, req_td, req_ep, req_attr, 1'b1)};
                            s_axis_tx_tkeep  <= 8'hFF;
                            s_axis_tx_tlast  <= 1'b0;
                        end else begin
                            state <= RD_WAIT;
                        end
`else
                        state   <= RD_WAIT;
`endif
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        data_q           <= rd_data;
                        state            <= HDR;
                        s_axis_tx_tvalid <= 1'b1;
                        s_axis_tx_tdata  <= {make_dw1(completer_id, ur_flag, rd_be),
                                             make_dw0(tc_q, td_q, ep_q, attr_q, ur_flag)};
                        s_axis_tx_tkeep  <= 8'hFF;
                        s_axis_tx_tlast  <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                HDR: begin
                    if (s_axis_tx_tready) begin
                        state           <= DATA;
                        s_axis_tx_tdata <= {(ur_flag ? 32'h0 : data_q),
                                            make_dw2(rid_q, tag_q, rd_addr[4:0], rd_be)};
                        s_axis_tx_tkeep <= ur_flag ? 8'h0F : 8'hFF;
                        s_axis_tx_tlast <= 1'b1;
                    end
                end
                DATA: begin
                    if (s_axis_tx_tready) begin
                        state            <= IDLE;
                        compl_done       <= 1'b1;
                        s_axis_tx_tvalid <= 1'b0;
                        s_axis_tx_tdata  <= '0;
                        s_axis_tx_tkeep  <= '0;
                        s_axis_tx_tlast  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_tx_cpl_engine.sv
// tb_pio_tx_cpl_engine: directed bench for pio_tx_cpl_engine with a beat scoreboard.
// Build with PIO_CPL_UR_EN defined to exercise the Unsupported Request path.
module tb_pio_tx_cpl_engine;

    localparam int RD_LAT = 2;

    logic        clk;
    logic        sys_rst;
    logic        req_compl;
    logic [2:0]  req_tc;
    logic        req_td;
    logic        req_ep;
    logic [1:0]  req_attr;
    logic [15:0] req_rid;
    logic [7:0]  req_tag;
    logic [3:0]  req_be;
    logic [13:0] req_addr;
    logic [15:0] completer_id;
    logic        compl_done;
    logic [13:0] rd_addr;
    logic [3:0]  rd_be;
    logic [31:0] rd_data;
    logic        s_axis_tx_tready;
    logic        s_axis_tx_tvalid;
    logic [63:0] s_axis_tx_tdata;
    logic [7:0]  s_axis_tx_tkeep;
    logic        s_axis_tx_tlast;
    logic [3:0]  s_axis_tx_tuser;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t       sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          req_cyc = 0;
    int          first_valid_cyc = 0;
    int          done_cyc = 0;
    int          done_count = 0;
    int          hs_count = 0;
    logic        prev_valid = 1'b0;
    logic        stall_pending = 1'b0;
    beat_t       held_beat;
    logic [63:0] last_beat0 = '0;
    logic [63:0] last_beat1 = '0;
    logic [7:0]  last_keep1 = '0;

    pio_tx_cpl_engine #(.TCQ(1), .RD_LAT(RD_LAT)) dut (
        .clk              (clk),
        .sys_rst          (sys_rst),
        .req_compl        (req_compl),
        .req_tc           (req_tc),
        .req_td           (req_td),
        .req_ep           (req_ep),
        .req_attr         (req_attr),
        .req_rid          (req_rid),
        .req_tag          (req_tag),
        .req_be           (req_be),
        .req_addr         (req_addr),
        .completer_id     (completer_id),
        .compl_done       (compl_done),
        .rd_addr          (rd_addr),
        .rd_be            (rd_be),
        .rd_data          (rd_data),
        .s_axis_tx_tready (s_axis_tx_tready),
        .s_axis_tx_tvalid (s_axis_tx_tvalid),
        .s_axis_tx_tdata  (s_axis_tx_tdata),
        .s_axis_tx_tkeep  (s_axis_tx_tkeep),
        .s_axis_tx_tlast  (s_axis_tx_tlast),
        .s_axis_tx_tuser  (s_axis_tx_tuser)
    );

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case the sequence gets stuck.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // One comparison: counts it and reports tag, observed and expected on failure.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [11:0] model_bc(input logic [3:0] be);
        if (be[3] && be[0])                                              model_bc = 12'd4;
        else if ((be[3:2] == 2'b01 && be[0]) || (be[3] && be[1:0] == 2'b10)) model_bc = 12'd3;
        else if (be == 4'd3 || be == 4'd6 || be == 4'd12)                model_bc = 12'd2;
        else                                                             model_bc = 12'd1;
    endfunction

    function automatic logic [1:0] model_lo2(input logic [3:0] be);
        model_lo2 = 2'd0;
        for (int i = 3; i >= 0; i--) if (be[i]) model_lo2 = 2'(i);
    endfunction

    // Drive one request pulse and push the two beats it must produce.
    task automatic applyStimulus(input logic [13:0] addr, input logic [3:0] be, input logic [7:0] tag,
                                 input logic [2:0] tc, input logic [1:0] attr, input logic td,
                                 input logic ep, input logic [15:0] rid, input logic [31:0] data);
        logic        ur;
        logic [31:0] dw0, dw1, dw2;
        beat_t       b;
`ifdef PIO_CPL_UR_EN
        ur = (addr[13:12] == 2'b00);
`else
        ur = 1'b0;
`endif
        dw0 = {1'b0, (ur ? 2'b00 : 2'b10), 5'b01010, 1'b0, tc, 4'b0000, td, ep, attr, 2'b00,
               (ur ? 10'd0 : 10'd1)};
        dw1 = {completer_id, (ur ? 3'b001 : 3'b000), 1'b0, model_bc(be)};
        dw2 = {rid, tag, 1'b0, addr[4:0], model_lo2(be)};
        b.d = {dw1, dw0}; b.k = 8'hFF; b.l = 1'b0;
        sb.push_back(b);
        b.d = {(ur ? 32'h0 : data), dw2}; b.k = ur ? 8'h0F : 8'hFF; b.l = 1'b1;
        sb.push_back(b);
        rd_data   = data;
        req_addr  = addr;
        req_be    = be;
        req_tag   = tag;
        req_tc    = tc;
        req_attr  = attr;
        req_td    = td;
        req_ep    = ep;
        req_rid   = rid;
        req_compl = 1'b1;
        req_cyc   = cyc;
        @(posedge clk); #1;
        req_compl = 1'b0;
    endtask

    // Bounded wait for the completion counter to reach a target.
    task automatic waitDone(input int target);
        for (int i = 0; i < 100 && done_count < target; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        assert (done_count >= target)
        else begin
            failures++;
            $error("[TB] FAIL done_timeout: observed=%0d expected=%0d", done_count, target);
        end
    endtask

    // Bounded wait for tvalid to rise.
    task automatic waitValid();
        for (int i = 0; i < 100 && s_axis_tx_tvalid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        assert (s_axis_tx_tvalid === 1'b1)
        else begin
            failures++;
            $error("[TB] FAIL valid_timeout: observed=%0b expected=1", s_axis_tx_tvalid);
        end
    endtask

    // Output monitor: AXI hold rule, scoreboard comparison on handshakes, done pulses.
    always @(negedge clk) begin
        beat_t cur, exp_b;
        cur = '{d: s_axis_tx_tdata, k: s_axis_tx_tkeep, l: s_axis_tx_tlast};
        if (s_axis_tx_tvalid === 1'b1 && prev_valid !== 1'b1) first_valid_cyc = cyc;
        prev_valid = s_axis_tx_tvalid;
        if (stall_pending) begin
            checkOutput("hold_valid", 64'(s_axis_tx_tvalid), 64'h1);
            checkOutput("hold_beat", cur.d ^ 64'(cur.k) ^ 64'(cur.l), held_beat.d ^ 64'(held_beat.k) ^ 64'(held_beat.l));
        end
        stall_pending = (s_axis_tx_tvalid === 1'b1) && (s_axis_tx_tready === 1'b0) && (sys_rst === 1'b0);
        held_beat = cur;
        if (s_axis_tx_tvalid === 1'b1 && s_axis_tx_tready === 1'b1) begin
            hs_count++;
            checks++;
            assert (sb.size() != 0)
            else begin
                failures++;
                $error("[TB] FAIL unexpected_beat: observed=%0h expected=none", cur.d);
            end
            if (sb.size() != 0) begin
                exp_b = sb.pop_front();
                checkOutput("beat_data", cur.d, exp_b.d);
                checkOutput("beat_keep", 64'(cur.k), 64'(exp_b.k));
                checkOutput("beat_last", 64'(cur.l), 64'(exp_b.l));
            end
            if (cur.l) begin
                last_beat1 = cur.d;
                last_keep1 = cur.k;
            end else begin
                last_beat0 = cur.d;
            end
        end
        if (compl_done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    // Directed sequence.
    initial begin
        int d0, h0;
        sys_rst = 1'b1; req_compl = 1'b0; req_tc = '0; req_td = 1'b0; req_ep = 1'b0;
        req_attr = '0; req_rid = '0; req_tag = '0; req_be = '0; req_addr = '0;
        completer_id = 16'h0300; rd_data = '0; s_axis_tx_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tvalid", 64'(s_axis_tx_tvalid), 64'h0);
        checkOutput("rst_tlast", 64'(s_axis_tx_tlast), 64'h0);
        checkOutput("rst_tdata", s_axis_tx_tdata, 64'h0);
        checkOutput("rst_tkeep", 64'(s_axis_tx_tkeep), 64'h0);
        checkOutput("rst_rd_addr", 64'(rd_addr), 64'h0);
        checkOutput("rst_rd_be", 64'(rd_be), 64'h0);
        checkOutput("rst_done", 64'(compl_done), 64'h0);
        checkOutput("rst_tuser", 64'(s_axis_tx_tuser), 64'h0);
        sys_rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] BAR0 ID read");
        applyStimulus(14'h1000, 4'hF, 8'h05, 3'd0, 2'd0, 1'b0, 1'b0, 16'h0001, 32'h67452301);
        checkOutput("rd_addr", 64'(rd_addr), 64'h1000);
        checkOutput("rd_be", 64'(rd_be), 64'hF);
        waitDone(1);
        checkOutput("id_dw0", 64'(last_beat0[31:0]), 64'h4A000001);
        checkOutput("id_bc", 64'(last_beat0[43:32]), 64'd4);
        checkOutput("id_lower_addr", 64'(last_beat1[6:0]), 64'h0);
        checkOutput("id_dw3", 64'(last_beat1[63:32]), 64'h67452301);
        checkOutput("first_beat_lat", 64'(first_valid_cyc - req_cyc), 64'(RD_LAT + 2));
        checkOutput("done_lat", 64'(done_cyc - req_cyc), 64'(RD_LAT + 4));

        $display("[TB] byte-enable decode");
        applyStimulus(14'h1002, 4'b0100, 8'h06, 3'd2, 2'd1, 1'b1, 1'b0, 16'h0102, 32'hA5A5_0001);
        waitDone(2);
        checkOutput("be0100_bc", 64'(last_beat0[43:32]), 64'd1);
        checkOutput("be0100_la", 64'(last_beat1[6:0]), 64'h0A);
        applyStimulus(14'h1002, 4'b0110, 8'h07, 3'd7, 2'd3, 1'b0, 1'b1, 16'h0103, 32'hA5A5_0002);
        waitDone(3);
        checkOutput("be0110_bc", 64'(last_beat0[43:32]), 64'd2);
        checkOutput("be0110_la", 64'(last_beat1[6:0]), 64'h09);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] be_tab [4];
            be_tab = '{4'b0000, 4'b1001, 4'b0101, 4'b1010};
            applyStimulus(14'h2010 + 14'(i), be_tab[i], 8'h10 + 8'(i), 3'd1, 2'd2, 1'b0, 1'b0,
                          16'hBEEF, 32'h1000_0000 + 32'(i));
            waitDone(4 + i);
        end

        $display("[TB] backpressure");
        d0 = done_count; h0 = hs_count;
        s_axis_tx_tready = 1'b0;
        applyStimulus(14'h3004, 4'hF, 8'h20, 3'd0, 2'd0, 1'b0, 1'b0, 16'h0200, 32'hDEAD_BEEF);
        waitValid();
        repeat (2) begin @(posedge clk); #1; end
        @(posedge clk); #1; s_axis_tx_tready = 1'b1;
        @(posedge clk); #1; s_axis_tx_tready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; s_axis_tx_tready = 1'b1;
        waitDone(d0 + 1);
        repeat (4) begin @(posedge clk); #1; end
        checkOutput("bp_handshakes", 64'(hs_count - h0), 64'd2);
        checkOutput("bp_done", 64'(done_count - d0), 64'd1);

        $display("[TB] busy ignore");
        d0 = done_count; h0 = hs_count;
        applyStimulus(14'h1008, 4'hF, 8'h11, 3'd0, 2'd0, 1'b0, 1'b0, 16'h0300, 32'h1111_1111);
        req_compl = 1'b1; req_tag = 8'h22; req_addr = 14'h2000;
        @(posedge clk); #1;
        req_compl = 1'b0;
        waitDone(d0 + 1);
        repeat (10) begin @(posedge clk); #1; end
        checkOutput("busy_tag", 64'(last_beat1[15:8]), 64'h11);
        checkOutput("busy_handshakes", 64'(hs_count - h0), 64'd2);
        checkOutput("busy_done", 64'(done_count - d0), 64'd1);

        $display("[TB] reset mid-packet");
        d0 = done_count; h0 = hs_count;
        s_axis_tx_tready = 1'b0;
        applyStimulus(14'h100C, 4'hF, 8'h33, 3'd0, 2'd0, 1'b0, 1'b0, 16'h0400, 32'h3333_3333);
        waitValid();
        s_axis_tx_tready = 1'b1;
        @(posedge clk); #1; s_axis_tx_tready = 1'b0;
        sys_rst = 1'b1;
        @(posedge clk); #1; sys_rst = 1'b0;
        checkOutput("rst_mid_tvalid", 64'(s_axis_tx_tvalid), 64'h0);
        checkOutput("rst_mid_done", 64'(compl_done), 64'h0);
        sb.delete();
        s_axis_tx_tready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        checkOutput("rst_mid_no_done", 64'(done_count - d0), 64'd0);
        checkOutput("rst_mid_handshakes", 64'(hs_count - h0), 64'd1);
        applyStimulus(14'h1010, 4'b0011, 8'h44, 3'd0, 2'd0, 1'b0, 1'b0, 16'h0500, 32'h4444_4444);
        waitDone(d0 + 1);
        checkOutput("after_rst_done_lat", 64'(done_cyc - req_cyc), 64'(RD_LAT + 4));

        $display("[TB] region 00 request");
        d0 = done_count;
        applyStimulus(14'h0004, 4'hF, 8'h55, 3'd0, 2'd0, 1'b0, 1'b0, 16'h0600, 32'h0);
        waitDone(d0 + 1);
`ifdef PIO_CPL_UR_EN
        checkOutput("ur_dw0", 64'(last_beat0[31:0]), 64'h0A000000);
        checkOutput("ur_status", 64'(last_beat0[47:45]), 64'h1);
        checkOutput("ur_keep1", 64'(last_keep1), 64'h0F);
        checkOutput("ur_first_beat_lat", 64'(first_valid_cyc - req_cyc), 64'd1);
`else
        checkOutput("r00_dw0", 64'(last_beat0[31:0]), 64'h4A000001);
        checkOutput("r00_keep1", 64'(last_keep1), 64'hFF);
        checkOutput("r00_first_beat_lat", 64'(first_valid_cyc - req_cyc), 64'(RD_LAT + 2));
`endif

        repeat (5) begin @(posedge clk); #1; end
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
